// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the mini CPU datapath.
// Optional CTRL_INSTR_COUNT_EN adds instr_count (retired non-illegal instructions).
module control_sequencer #(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            Run,
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic [OPW-1:0]  op,
  output logic            Done,
  output logic            Halted,
  output logic            Illegal
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [31:0]     instr_count
`endif
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state, state_nx;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic is_md, is_two, is_un;
  logic is_nop, is_halt, is_bad;
  logic ill_now, illegal_q;
  logic unused_ir;

  assign opc = IR[31:27];
  assign ra  = IR[26:23];
  assign rb  = IR[22:19];
  assign rc  = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_md   = (opc == 5'd15) || (opc == 5'd16);
  assign is_two  = (opc <= 5'd8) || is_md;
  assign is_un   = (opc == 5'd17) || (opc == 5'd18);
  assign is_nop  = (opc == 5'd26);
  assign is_halt = (opc == 5'd27);
  assign is_bad  = !(is_two || is_un || is_nop || is_halt);

  assign ill_now = (state == S_T3) && is_bad;
  assign Illegal = illegal_q || ill_now;

  // Falling-edge update keeps strobes settled for the rising-edge datapath
  always_ff @(negedge Clock or posedge clear) begin
    if (clear) begin
      state     <= S_RESET;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      illegal_q <= illegal_q || ill_now;
    end
  end

`ifdef CTRL_INSTR_COUNT_EN
  always_ff @(negedge Clock or posedge clear) begin
    if (clear)
      instr_count <= '0;
    else if (Done && !ill_now)
      instr_count <= instr_count + 32'd1;
  end
`endif

  always_comb begin
    state_nx = state;
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rout     = '0;
    Rin      = '0;
    op       = '0;
    Done     = 1'b0;
    Halted   = 1'b0;
    case (state)
      S_RESET: begin
        if (Run) state_nx = S_T0;
      end
      S_T0: begin
        PCout    = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        Zin      = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        Zlowout  = 1'b1;
        PCin     = 1'b1;
        Read     = 1'b1;
        MDRin    = 1'b1;
        state_nx = S_T2;
      end
      S_T2: begin
        MDRout   = 1'b1;
        IRin     = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        unique case (1'b1)
          is_two: begin
            Rout     = NREG'(1) << rb;
            Yin      = 1'b1;
            state_nx = S_T4;
          end
          is_un: begin
            state_nx = S_T4;
          end
          is_halt: begin
            Done     = 1'b1;
            state_nx = S_HALT;
          end
          default: begin
            Done     = 1'b1;
            state_nx = Run ? S_T0 : S_RESET;
          end
        endcase
      end
      S_T4: begin
        Rout     = NREG'(1) << (is_un ? rb : rc);
        op       = OPW'(opc);
        Zin      = 1'b1;
        state_nx = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_md) begin
          LOin     = 1'b1;
          state_nx = S_T6;
        end else begin
          Rin      = NREG'(1) << ra;
          Done     = 1'b1;
          state_nx = Run ? S_T0 : S_RESET;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        Done     = 1'b1;
        state_nx = Run ? S_T0 : S_RESET;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: state_nx = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: instruction-level model pushes
// per-cycle expected strobe vectors; a monitor compares on rising edges.
module tb_control_sequencer;
  localparam int NREG = 16;
  localparam int OPW  = 5;

  logic Clock = 1'b0;
  logic clear, Run;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic IncPC, Read, Done, Halted, Illegal;
  logic [NREG-1:0] Rout, Rin;
  logic [OPW-1:0] op;
`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  control_sequencer #(.NREG(NREG), .OPW(OPW)) dut (
    .Clock(Clock), .clear(clear), .Run(Run), .IR(IR),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
    .op(op), .Done(Done), .Halted(Halted), .Illegal(Illegal)
`ifdef CTRL_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [5:0]  drv;
    logic [9:0]  ld;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  op;
    logic        done;
    logic        halted;
    logic        illegal;
  } vec_t;

  localparam int D_PC = 5, D_ZH = 4, D_ZL = 3, D_MDR = 2;
  localparam int L_MAR = 9, L_PC = 8, L_MDR = 7, L_IR = 6;
  localparam int L_Y = 5, L_Z = 4, L_HI = 3, L_LO = 2;
  localparam int L_INC = 1, L_RD = 0;

  vec_t act;
  assign act.drv  = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout};
  assign act.ld   = {MARin, PCin, MDRin, IRin, Yin, Zin,
                     HIin, LOin, IncPC, Read};
  assign act.rout = Rout;
  assign act.rin  = Rin;
  assign act.op   = op;
  assign act.done = Done;
  assign act.halted  = Halted;
  assign act.illegal = Illegal;

  vec_t exp_q[$];
  int   tag_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   step = 0;
  bit   sticky = 0;
  int   cnt_model = 0;

  always @(posedge Clock) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL step%0d: got %h want %h", t, act, e);
      end
    end
  end

  function automatic vec_t blank();
    vec_t v;
    v = '0;
    v.illegal = sticky;
    return v;
  endfunction

  task automatic push(input vec_t v);
    exp_q.push_back(v);
    tag_q.push_back(step);
    step++;
  endtask

  // Expected strobe vectors for one instruction, from its opcode class
  task automatic expect_instr(input logic [31:0] ir, input int maxlen,
                              output int len);
    vec_t s[$];
    vec_t v;
    int opc, ra, rb, rc;
    bit two, md, un;
    opc = int'(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    md  = (opc == 15 || opc == 16);
    two = (opc <= 8) || md;
    un  = (opc == 17 || opc == 18);
    v = blank();
    v.drv[D_PC] = 1; v.ld[L_MAR] = 1; v.ld[L_INC] = 1; v.ld[L_Z] = 1;
    s.push_back(v);
    v = blank();
    v.drv[D_ZL] = 1; v.ld[L_PC] = 1; v.ld[L_RD] = 1; v.ld[L_MDR] = 1;
    s.push_back(v);
    v = blank();
    v.drv[D_MDR] = 1; v.ld[L_IR] = 1;
    s.push_back(v);
    if (two || un) begin
      v = blank();
      if (two) begin
        v.rout = 16'(1) << rb;
        v.ld[L_Y] = 1;
      end
      s.push_back(v);
      v = blank();
      v.rout = 16'(1) << (un ? rb : rc);
      v.op = 5'(opc);
      v.ld[L_Z] = 1;
      s.push_back(v);
      v = blank();
      v.drv[D_ZL] = 1;
      if (md) v.ld[L_LO] = 1;
      else begin
        v.rin = 16'(1) << ra;
        v.done = 1;
      end
      s.push_back(v);
      if (md) begin
        v = blank();
        v.drv[D_ZH] = 1; v.ld[L_HI] = 1; v.done = 1;
        s.push_back(v);
      end
    end else begin
      if (opc != 26 && opc != 27) sticky = 1;
      v = blank();
      v.done = 1;
      s.push_back(v);
    end
    len = s.size();
    for (int i = 0; i < len && i < maxlen; i++) begin
      if (s[i].done && !(s[i].illegal && opc != 26 && opc != 27))
        cnt_model++;
      push(s[i]);
    end
  endtask

  // Called #1 after a falling edge with the DUT sitting in RESET
  task automatic restart();
    push(blank());
    clear = 0;
    Run = 1;
    @(negedge Clock); #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input bit drop);
    int len, k;
    IR = ir;
    expect_instr(ir, 99, len);
    k = drop ? int'($urandom_range(1, len - 1)) : -1;
    for (int i = 0; i < len; i++) begin
      if (i == k) Run = 0;
      @(negedge Clock); #1;
    end
    if (!Run) begin
      repeat ($urandom_range(0, 2)) begin
        push(blank());
        @(negedge Clock); #1;
      end
      restart();
    end
  endtask

  function automatic logic [31:0] rand_ir(input bit allow_bad);
    logic [4:0] opc;
    int pick;
    pick = int'($urandom_range(0, allow_bad ? 14 : 13));
    if (pick <= 8) opc = 5'(pick);
    else if (pick == 9) opc = 5'd15;
    else if (pick == 10) opc = 5'd16;
    else if (pick == 11) opc = 5'd17;
    else if (pick == 12) opc = 5'd18;
    else if (pick == 13) opc = 5'd26;
    else opc = 5'(19 + $urandom_range(0, 6));
    return {opc, 27'($urandom)};
  endfunction

  initial begin
    int len;
    clear = 1;
    Run = 0;
    IR = 32'h0;
    repeat (2) @(negedge Clock);
    #1;
    push(blank());
    @(negedge Clock); #1;
    clear = 0;
    repeat (2) begin
      push(blank());
      @(negedge Clock); #1;
    end
    restart();

    run_instr(32'h0091_8000, 0);
    run_instr(32'h1091_8000, 0);
    run_instr(32'h7813_0000, 0);
    run_instr(32'h8091_8000, 0);
    run_instr(32'hD000_0000, 0);
    run_instr(32'h0091_8000, 1);
    for (int n = 0; n < 40; n++)
      run_instr(rand_ir(n > 20), $urandom_range(0, 4) == 0);

    // abort an add in T4 with clear
    IR = 32'h0091_8000;
    expect_instr(IR, 5, len);
    repeat (4) @(negedge Clock);
    @(posedge Clock); #2;
    clear = 1;
    sticky = 0;
    cnt_model = 0;
    #1;
    compared++;
    if (act !== '0) begin
      mismatched++;
      $display("FAIL clear_abort: got %h want 0", act);
    end
    @(negedge Clock); #1;
    push(blank());
    @(negedge Clock); #1;
    restart();

    run_instr(32'h0091_8000, 0);
    run_instr(32'h0091_8000, 0);
    run_instr(32'hF800_0000, 0);
    IR = 32'hD800_0000;
    expect_instr(IR, 99, len);
    repeat (len) @(negedge Clock);
    #1;
    repeat (20) begin
      vec_t h;
      h = blank();
      h.halted = 1;
      push(h);
      @(negedge Clock); #1;
    end
`ifdef CTRL_INSTR_COUNT_EN
    compared++;
    if (instr_count !== 32'(cnt_model)) begin
      mismatched++;
      $display("FAIL instr_count: got %0d want %0d",
               instr_count, cnt_model);
    end
`endif
    @(posedge Clock); #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    clear = 1;
    repeat (2) @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the mini CPU. It generates the datapath control strobes (register out/in selects, MDR/MAR/PC/IR/Y/Z/HI/LO strobes, Read, ALU op) from the instruction in IR.
- It replaces manual strobe sequencing with a fetch/decode/execute FSM.
- It sits beside data_path and drives its control inputs. IR contents are fed back from the datapath.

Parameters:
- NREG, 16, number of general registers; width of Rout/Rin.
- OPW, 5, ALU op / opcode width.

Ports:
- Clock  in  1  system clock.
- clear  in  1  reset, asynchronous, active-high; single clock domain.
- Run  in  1  level; while high, the sequencer fetches and executes.
- IR  in  32  current instruction. Fields: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout  out  1 each  bus drive selects.
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read  out  1 each  load strobes. Zin loads both Z halves.
- Rout  out  NREG  one-hot register bus drive.
- Rin  out  NREG  one-hot register load.
- op  out  OPW  ALU operation code.
- Done  out  1  one-cycle pulse in the last state of each instruction.
- Halted  out  1  high while in HALT.
- Illegal  out  1  sticky; set on an undefined opcode.

Behaviour:
- State register updates on the falling edge of Clock, so strobes are stable before the datapath's rising-edge capture. All outputs decode from the state register and IR only (Moore).
- clear high asynchronously forces state RESET: all strobes 0, Rout = Rin = 0, op = 0, Done = 0, Halted = 0, Illegal = 0. clear mid-instruction aborts it with no further strobes.
- At most one bus driver is active in any state; Rout and Rin are each one-hot or zero.
- States and transitions:
  - RESET: to T0 when Run = 1; stays in RESET while Run = 0.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin. Then T3.
  - T3 (decode, IR now valid):
    - add/sub/and/or/shr/shra/shl/ror/rol (00000..01000), mul (01111), div (10000): Rout[Rb], Yin. Next T4.
    - neg/not (10001, 10010): no strobes. Next T4.
    - nop (11010): Done. Next T0, or RESET if Run = 0.
    - halt (11011): Done. Next HALT.
    - any other opcode: Illegal set, Done. Treated as nop.
  - T4:
    - two-operand ops: Rout[Rc], op = opcode, Zin.
    - neg/not: Rout[Rb], op = opcode, Zin.
  - T5:
    - mul/div: Zlowout, LOin. Next T6.
    - others: Zlowout, Rin[Ra], Done. Next T0, or RESET if Run = 0.
  - T6: Zhighout, HIin, Done. Next T0/RESET as in T5.
  - HALT: no strobes, Halted = 1. Left only via clear.
- op is 0 outside T4.
- Run is sampled only at instruction boundaries. Dropping Run mid-instruction lets the current instruction finish.
- Latency, T0 to the Done cycle inclusive:
  - ALU and neg/not: 6 cycles.
  - mul/div: 7 cycles.
  - nop, halt, illegal: 4 cycles.
- Register index fields are used as is. Ra = Rb = Rc is legal.

Optional Feature:
- Macro: CTRL_INSTR_COUNT_EN.
- When defined: adds output instr_count[31:0]. It increments on each Done, excluding illegal-opcode Dones. It wraps from FFFFFFFF to 0 and is cleared by clear.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- clear = 1 mid-T4 of an add → within the same cycle all strobes = 0 and Rout = Rin = 0; with Run = 1 after release, fetch restarts at T0.
- IR = 32'h0091_8000 (add R1,R2,R3), Run = 1 →
  - T0–T2 fetch strobes as above.
  - T3: Rout = 16'h0004, Yin.
  - T4: Rout = 16'h0008, op = 0, Zin.
  - T5: Zlowout, Rin = 16'h0002, Done.
  - 6 cycles total.
- IR = 32'h1091_8000 (and) → T4 op = 5'b00010. Datapath preloaded R2 = 12, R3 = 5 → R1 = 4 after Done.
- IR = 32'h7813_0000 (mul R2,R6) →
  - T4: Rout = 16'h0040, op = 5'b01111.
  - T5: Zlowout + LOin.
  - T6: Zhighout + HIin + Done.
  - Rin stays 0 throughout; 7 cycles total.
- IR = 32'hF800_0000 → Illegal = 1 and Done at T3, no Rin. Next IR = 32'hD800_0000 → Halted = 1, and no strobes for 20 cycles.
- With CTRL_INSTR_COUNT_EN: add, add, illegal, halt → instr_count = 3.
